// File: rtl/param_ram_loader_pkg.sv
// Shared coprocessor definitions for the parameter RAM load sequencer.
package param_ram_loader_pkg;

  // Loader FSM states. IDLE is transient after reset; LOAD writes words,
  // DRAIN swallows the tail of an over-long frame, VALID freezes the RAM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } ldr_state_t;

  // Width of the good-frame counter; it wraps naturally.
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/param_ram_loader.sv
// Load sequencer for the coprocessor parameter RAM. Writes exactly DEPTH
// words per framed stream, flags malformed frames, and holds the RAM
// frozen (stream back-pressured) while the compute engine reads it.
//
// Handshake: a stream beat transfers on a rising edge where s_tvalid and
// s_tready are both high; s_tready is a pure decode of the state register,
// so it never depends combinationally on s_tvalid or any other input.
module param_ram_loader
  import param_ram_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   ram_we,
  output logic [AW-1:0]          ram_w_addr,
  output logic [WIDTH-1:0]       ram_di,
  output logic                   data_valid,
  input  logic                   compute_done,
  input  logic                   err_clr,
  output logic                   load_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [1:0]             dbg_state
);

  ldr_state_t             r_state;
  ldr_state_t             w_state_next;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          w_ptr_next;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_load_err;
  logic                   w_err_set;
  logic                   w_cnt_inc;
  logic                   w_accept;
  logic                   w_ptr_last;

  // Output decode: ready/valid come only from the state register.
  assign s_tready   = (r_state == LOAD) || (r_state == DRAIN);
  assign data_valid = (r_state == VALID);
  assign w_accept   = s_tvalid && s_tready;
  assign w_ptr_last = (r_wr_ptr == AW'(DEPTH - 1));

  // Zero-latency write path straight from the stream into the RAM port.
  assign ram_we     = w_accept && (r_state == LOAD);
  assign ram_w_addr = r_wr_ptr;
  assign ram_di     = s_tdata;

  assign load_err   = r_load_err;
  assign frame_cnt  = r_frame_cnt;
  assign dbg_state  = r_state;

  // Next-state, pointer and error/counter event decode.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_wr_ptr;
    w_err_set    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IDLE: w_state_next = LOAD;
      LOAD: begin
        if (w_accept) begin
          if (w_ptr_last) begin
            w_ptr_next = '0;
            if (s_tlast) begin
              w_cnt_inc    = 1'b1;
              w_state_next = VALID;
            end else begin
              // Over-long frame: last slot is written, the rest discarded.
              w_err_set    = 1'b1;
              w_state_next = DRAIN;
            end
          end else if (s_tlast) begin
            // Short frame: restart at address 0 and keep loading.
            w_err_set  = 1'b1;
            w_ptr_next = '0;
          end else begin
            w_ptr_next = r_wr_ptr + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (w_accept && s_tlast) w_state_next = LOAD;
      end
      VALID: begin
        if (compute_done) w_state_next = LOAD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, pointer, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_frame_cnt <= '0;
      r_load_err  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_wr_ptr <= w_ptr_next;
      if (w_cnt_inc) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      // A new error in the same cycle as a clear keeps the flag set.
      if (w_err_set)    r_load_err <= 1'b1;
      else if (err_clr) r_load_err <= 1'b0;
    end
  end

endmodule
